// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite encodings and memory slave state type
// Shared by the memory slave, its lane decoder and the bench.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;
   localparam logic [2:0] HBURST_WRAP4  = 3'd2;
   localparam logic [2:0] HBURST_INCR4  = 3'd3;
   localparam logic [2:0] HBURST_WRAP8  = 3'd4;
   localparam logic [2:0] HBURST_INCR8  = 3'd5;
   localparam logic [2:0] HBURST_WRAP16 = 3'd6;
   localparam logic [2:0] HBURST_INCR16 = 3'd7;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } slave_state_e;

endpackage

// File: rtl/ahb_byte_lane_decode.sv
// rtl/ahb_byte_lane_decode.sv - transfer size and address low bits to byte strobes
// Little-endian: lane i carries byte address (addr_lo + k) when i == addr_lo + k.
module ahb_byte_lane_decode #(
   parameter int DATA_WIDTH = 32,
   localparam int NB = DATA_WIDTH / 8,
   localparam int LB = $clog2(NB)
) (
   input  logic [2:0]    size,
   input  logic [LB-1:0] addr_lo,
   output logic [NB-1:0] strb
);

   always_comb begin
      strb = '0;
      for (int i = 0; i < NB; i++) begin
         if ((i >= int'(addr_lo)) && (i < int'(addr_lo) + (1 << size))) begin
            strb[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_param_mem_slave.sv
// rtl/ahb_param_mem_slave.sv - parametrised AHB-Lite on-chip RAM target
// Wait states, byte-lane writes and the two-cycle ERROR response.
module ahb_param_mem_slave
   import ahb_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    MEM_DEPTH   = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [1:0]            HTRANS,
   input  logic                  HMASTLOCK,
   input  logic                  HREADY,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [DATA_WIDTH-1:0] HRDATA
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int LB    = $clog2(NB);
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
   localparam logic [2:0]            WS_LAST = 3'(WAIT_STATES - 1);

   slave_state_e          state_q, state_d, accept_state;
   logic [2:0]            wcnt_q, wcnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [LB-1:0]         lane_q, lane_d;
   logic [2:0]            size_q, size_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] offset, word_a;
   logic                  accept, addr_err;
   logic [NB-1:0]         strb;
   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic                  unused_inputs;

   assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

   always_comb begin
      offset   = HADDR - BASE_ADDR;
      word_a   = offset >> LB;
      addr_err = (HADDR < BASE_ADDR) || (word_a >= DEPTH_A) || (HSIZE > 3'(LB)) ||
                 ((HADDR & ((ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1))) != '0);
      // Only states that drive HREADYOUT high can close an address phase
      accept   = HSEL && HREADY && HTRANS[1] &&
                 ((state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2));
      if (addr_err) begin
         accept_state = ST_ERR1;
      end else if (WAIT_STATES > 0) begin
         accept_state = ST_WAIT;
      end else begin
         accept_state = ST_DATA;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      idx_d   = idx_q;
      lane_d  = lane_q;
      size_d  = size_q;
      write_d = write_q;
      if (accept) begin
         idx_d   = word_a[IDX_W-1:0];
         lane_d  = HADDR[LB-1:0];
         size_d  = HSIZE;
         write_d = HWRITE;
         wcnt_d  = '0;
      end
      case (state_q)
         ST_IDLE, ST_DATA, ST_ERR2: state_d = accept ? accept_state : ST_IDLE;
         ST_WAIT: begin
            if (wcnt_q == WS_LAST) begin
               state_d = ST_DATA;
               wcnt_d  = '0;
            end else begin
               wcnt_d = wcnt_q + 3'd1;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
         idx_q   <= '0;
         lane_q  <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         idx_q   <= idx_d;
         lane_q  <= lane_d;
         size_q  <= size_d;
         write_q <= write_d;
      end
   end

   ahb_byte_lane_decode #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .size    (size_q),
      .addr_lo (lane_q),
      .strb    (strb)
   );

   // Reset in the closing cycle drops the write; contents survive reset
   always_ff @(posedge HCLK) begin
      if (HRESETn && (state_q == ST_DATA) && write_q) begin
         for (int i = 0; i < NB; i++) begin
            if (strb[i]) begin
               mem_q[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
         end
      end
   end

   assign HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
   assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   assign HRDATA    = ((state_q == ST_DATA) && !write_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_ahb_param_mem_slave.sv
// tb/tb_ahb_param_mem_slave.sv - pipelined AHB master bench with byte-level memory model
// Two slaves: zero wait states at base 0, two wait states at base 0x100.
module tb_ahb_param_mem_slave;
   import ahb_pkg::*;

   localparam int          DEPTH = 64;
   localparam logic [31:0] BASE2 = 32'h100;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [1:0]  trans;
      logic [31:0] wdata;
   } beat_t;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        hsel0, hsel2, hwrite, hmastlock;
   logic [31:0] haddr, hwdata;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic        rdy0, rdy2, resp0, resp2;
   logic [31:0] rd0, rd2;

   beat_t      q[$];
   logic [7:0] mm [2][4*DEPTH];
   int         total = 0;
   int         bad = 0;

   always #5 HCLK = ~HCLK;

   ahb_param_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH),
                         .BASE_ADDR(32'h0), .WAIT_STATES(0)) u0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
      .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
      .HMASTLOCK(hmastlock), .HREADY(rdy0), .HWDATA(hwdata),
      .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0));

   ahb_param_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH),
                         .BASE_ADDR(BASE2), .WAIT_STATES(2)) u2 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel2), .HADDR(haddr), .HWRITE(hwrite),
      .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
      .HMASTLOCK(hmastlock), .HREADY(rdy2), .HWDATA(hwdata),
      .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rd2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] base_of(input int d);
      return (d != 0) ? BASE2 : 32'h0;
   endfunction

   function automatic bit is_err(input int d, input beat_t b);
      logic [31:0] off;
      if (b.addr < base_of(d)) return 1'b1;
      off = b.addr - base_of(d);
      if (off / 4 >= DEPTH) return 1'b1;
      if (b.size > 3'd2) return 1'b1;
      if (b.addr % (32'd1 << b.size) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_read(input int d, input logic [31:0] addr);
      int w;
      w = int'((addr - base_of(d)) & ~32'd3);
      return {mm[d][w+3], mm[d][w+2], mm[d][w+1], mm[d][w]};
   endfunction

   task automatic model_write(input int d, input beat_t b);
      int off;
      off = int'(b.addr - base_of(d));
      for (int k = 0; k < (1 << b.size); k++) begin
         mm[d][off+k] = b.wdata[8*((off+k)%4) +: 8];
      end
   endtask

   task automatic push(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [1:0] trans, input logic [31:0] wdata);
      beat_t b;
      b.wr = wr; b.addr = addr; b.size = size; b.trans = trans; b.wdata = wdata;
      q.push_back(b);
   endtask

   // Pipelined master: address of beat i overlaps the data phase of the previous beat.
   task automatic run(input int d);
      int    i = 0;
      bit    pend = 1'b0;
      beat_t pb;
      int    low = 0;
      logic  rdy, resp;
      logic [31:0] rd;
      bit    xfer, exp_err;
      int    exp_low;
      while (i < q.size() || pend) begin
         if (i < q.size()) begin
            hsel0 = (d == 0); hsel2 = (d != 0);
            haddr = q[i].addr; hwrite = q[i].wr; hsize = q[i].size; htrans = q[i].trans;
         end else begin
            hsel0 = 1'b0; hsel2 = 1'b0; htrans = HTRANS_IDLE;
         end
         hwdata = pend ? pb.wdata : 32'h0;
         @(negedge HCLK);
         rdy  = (d != 0) ? rdy2 : rdy0;
         resp = (d != 0) ? resp2 : resp0;
         rd   = (d != 0) ? rd2 : rd0;
         if (pend) begin
            xfer    = pb.trans[1];
            exp_err = xfer && is_err(d, pb);
            exp_low = !xfer ? 0 : (exp_err ? 1 : ((d != 0) ? 2 : 0));
            if (!rdy) begin
               chk("resp_stall", 32'(resp), 32'(exp_err));
               low++;
               if (low > 10) begin
                  chk("stall_bound", 32'(low), 32'(exp_low));
                  pend = 1'b0;
                  i = q.size();
               end
            end else begin
               chk("wait_cycles", 32'(low), 32'(exp_low));
               chk("resp", 32'(resp), 32'(exp_err));
               if (xfer && !exp_err && pb.wr) model_write(d, pb);
               chk("rdata", rd, (xfer && !exp_err && !pb.wr) ? model_read(d, pb.addr) : 32'h0);
               pend = 1'b0;
               low = 0;
            end
         end
         @(posedge HCLK);
         #1;
         if (rdy && i < q.size()) begin
            pb = q[i];
            pend = 1'b1;
            i++;
         end
      end
      hsel0 = 1'b0; hsel2 = 1'b0; htrans = HTRANS_IDLE;
      q.delete();
   endtask

   task automatic rand_seq(input int d, input int n);
      logic [31:0] a;
      logic [2:0]  sz;
      logic [1:0]  tr;
      int          r;
      for (int k = 0; k < n; k++) begin
         sz = 3'($urandom_range(0, 3));
         a  = base_of(d) - ((d != 0) ? 32'd8 : 32'd0) + 32'($urandom_range(0, 4*DEPTH + 15));
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         r  = $urandom_range(0, 9);
         tr = (r == 0) ? HTRANS_IDLE : (r == 1) ? HTRANS_BUSY : (r < 6) ? HTRANS_NONSEQ : HTRANS_SEQ;
         push(1'($urandom_range(0, 1)), a, sz, tr, $urandom);
      end
      run(d);
   endtask

   initial begin
      HRESETn = 1'b0; hsel0 = 1'b0; hsel2 = 1'b0; haddr = 32'h0; hwrite = 1'b0;
      hsize = HSIZE_WORD; hburst = HBURST_SINGLE; hprot = 4'h0; htrans = HTRANS_IDLE;
      hmastlock = 1'b0; hwdata = 32'h0;
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      chk("rst_ready0", 32'(rdy0), 32'd1);
      chk("rst_resp0", 32'(resp0), 32'd0);
      chk("rst_rdata0", rd0, 32'h0);
      chk("rst_ready2", 32'(rdy2), 32'd1);
      chk("rst_resp2", 32'(resp2), 32'd0);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;

      for (int d = 0; d < 2; d++) begin
         for (int w = 0; w < DEPTH; w++) push(1'b1, base_of(d) + 32'(4*w), HSIZE_WORD, HTRANS_NONSEQ, $urandom);
         run(d);
      end

      hburst = HBURST_INCR4;
      for (int k = 0; k < 4; k++) push(1'b1, 32'(4*k), HSIZE_WORD, (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'(k+1));
      for (int k = 0; k < 4; k++) push(1'b0, 32'(4*k), HSIZE_WORD, (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h0);
      run(0);
      hburst = HBURST_SINGLE;

      push(1'b1, BASE2 + 32'h10, HSIZE_WORD, HTRANS_NONSEQ, 32'hDEADBEEF);
      run(1);
      push(1'b0, BASE2 + 32'h10, HSIZE_WORD, HTRANS_NONSEQ, 32'h0);
      run(1);

      push(1'b1, 32'h20, HSIZE_WORD, HTRANS_NONSEQ, 32'h11223344);
      push(1'b1, 32'h21, HSIZE_BYTE, HTRANS_NONSEQ, 32'h0000AA00);
      push(1'b1, 32'h22, HSIZE_HALF, HTRANS_NONSEQ, 32'hBBCC0000);
      push(1'b0, 32'h20, HSIZE_WORD, HTRANS_NONSEQ, 32'h0);
      run(0);

      push(1'b1, 32'hFC, HSIZE_WORD, HTRANS_NONSEQ, 32'hCAFEF00D);
      push(1'b1, 32'h100, HSIZE_WORD, HTRANS_NONSEQ, 32'h99999999);
      push(1'b1, 32'h1, HSIZE_HALF, HTRANS_NONSEQ, 32'h77777777);
      push(1'b1, 32'h0, HSIZE_DWORD, HTRANS_NONSEQ, 32'h66666666);
      push(1'b0, 32'h0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0);
      push(1'b0, 32'hFC, HSIZE_WORD, HTRANS_NONSEQ, 32'h0);
      run(0);
      push(1'b1, BASE2 - 32'h4, HSIZE_WORD, HTRANS_NONSEQ, 32'h12121212);
      push(1'b1, BASE2 + 32'hFC, HSIZE_WORD, HTRANS_NONSEQ, 32'h34343434);
      push(1'b0, BASE2 + 32'hFC, HSIZE_WORD, HTRANS_NONSEQ, 32'h0);
      run(1);

      push(1'b1, 32'h30, HSIZE_WORD, HTRANS_NONSEQ, 32'h55);
      push(1'b0, 32'h30, HSIZE_WORD, HTRANS_NONSEQ, 32'h0);
      push(1'b1, 32'h34, HSIZE_WORD, HTRANS_NONSEQ, 32'hA5A5A5A5);
      push(1'b1, 32'h30, HSIZE_WORD, HTRANS_BUSY, 32'hFFFFFFFF);
      push(1'b1, 32'h38, HSIZE_WORD, HTRANS_SEQ, 32'h5A5A5A5A);
      push(1'b1, 32'h30, HSIZE_WORD, HTRANS_IDLE, 32'hEEEEEEEE);
      push(1'b0, 32'h30, HSIZE_WORD, HTRANS_NONSEQ, 32'h0);
      push(1'b0, 32'h34, HSIZE_WORD, HTRANS_NONSEQ, 32'h0);
      push(1'b0, 32'h38, HSIZE_WORD, HTRANS_NONSEQ, 32'h0);
      run(0);

      hsel2 = 1'b1; haddr = BASE2 + 32'h10; hwrite = 1'b1; hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ;
      @(posedge HCLK); #1;
      hsel2 = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h12345678; HRESETn = 1'b0;
      @(negedge HCLK);
      chk("wait_before_rst", 32'(rdy2), 32'd0);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      @(negedge HCLK);
      chk("post_rst_ready", 32'(rdy2), 32'd1);
      chk("post_rst_resp", 32'(resp2), 32'd0);
      chk("post_rst_rdata", rd2, 32'h0);
      repeat (3) @(posedge HCLK);
      #1;
      push(1'b0, BASE2 + 32'h10, HSIZE_WORD, HTRANS_NONSEQ, 32'h0);
      run(1);

      rand_seq(0, 300);
      rand_seq(1, 200);
      for (int d = 0; d < 2; d++) begin
         for (int w = 0; w < DEPTH; w++) push(1'b0, base_of(d) + 32'(4*w), HSIZE_WORD, HTRANS_SEQ, 32'h0);
         run(d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ahb_param_mem_slave.md
Name: ahb_param_mem_slave

Overview:
Parametrised AHB-Lite memory slave. It is the next generation of the team's fixed 32-bit AHB_Slave. It adds:
- configurable data width, memory depth and base address;
- programmable wait states;
- byte/halfword lane writes;
- the two-cycle ERROR response.

It sits behind the AHB decoder/mux as a generic on-chip RAM target.

Parameters:
- DATA_WIDTH, 32, bus data width; legal values 32 or 64.
- ADDR_WIDTH, 32, HADDR width.
- MEM_DEPTH, 1024, number of DATA_WIDTH-bit words.
- BASE_ADDR, 0, byte address of word 0; must be aligned to DATA_WIDTH/8.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase; range 0..7.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESETn  in  1  synchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_WIDTH  byte address.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type; informational only.
- HPROT  in  4  protection; ignored.
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
- HMASTLOCK  in  1  locked transfer; ignored.
- HREADY  in  1  bus-wide ready (mux output).
- HWDATA  in  DATA_WIDTH  write data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DATA_WIDTH  read data.

Behaviour:
- Reset: HRESETn sampled low at a rising HCLK edge gives:
  - state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0;
  - wait counter 0; any pending write is discarded (not committed);
  - memory contents are not cleared.
- Address phase accept: HSEL & HREADY & HTRANS[1] (NONSEQ or SEQ) at a rising edge. On accept, register HADDR, HWRITE and HSIZE.
- IDLE or BUSY with HSEL: no transfer; zero-wait OKAY response.
- Error check at accept. A transfer errors if any of these hold:
  - HADDR < BASE_ADDR;
  - word index >= MEM_DEPTH;
  - HSIZE > log2(DATA_WIDTH/8);
  - HADDR not aligned to 2^HSIZE.
- States:
  - IDLE: HREADYOUT=1. On an accepted, error-free transfer go to WAIT if WAIT_STATES>0, else DATA. On an accepted erroring transfer go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Count WAIT_STATES cycles, then go to DATA.
  - DATA: HREADYOUT=1, HRESP=0; final data-phase cycle.
    - Write: commit at the closing edge. Byte lanes come from HSIZE and HADDR[log2(DATA_WIDTH/8)-1:0], little-endian; unselected bytes are unchanged.
    - Read: HRDATA = mem[registered index], full word; HRDATA=0 in all other cycles.
    - A new accept in the same cycle pipelines directly to WAIT/DATA/ERR1; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; always proceeds to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. No memory access. May accept the next address phase.
- Abort: if the master drives IDLE during ERR1, ERR2 still completes and the address is ignored. During ERR2 the master's IDLE is accepted as no-transfer.
- Latency: an OKAY transfer completes 1+WAIT_STATES cycles after accept. An ERROR transfer takes exactly 2 cycles.
- Write-then-read to the same address back-to-back: the read returns the new data. The write commits before the read's data phase, so no forwarding is needed.
- Burst beats: each beat is an independent address phase. SEQ and NONSEQ are treated identically, including across wrap boundaries.
- HREADY low (another slave stalling) with HSEL high: no accept; state holds.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HBURST_SINGLE..INCR16;
  - HSIZE_BYTE/HALF/WORD/DWORD;
  - HRESP_OKAY/ERROR;
  - slave state enum.
- Sub-module ahb_byte_lane_decode: (HSIZE, addr low bits) -> DATA_WIDTH/8 byte-strobe vector.

Test Plan:
1. WAIT_STATES=0, DATA_WIDTH=32: INCR4 write of 1,2,3,4 to 0x0..0xC, then INCR4 read -> HRDATA 1,2,3,4 on consecutive cycles; HREADYOUT stays 1; HRESP 0.
2. WAIT_STATES=2: single write of 0xDEADBEEF to 0x10 -> HREADYOUT low exactly 2 cycles, then high; a read of 0x10 then returns 0xDEADBEEF after 2 wait cycles.
3. Byte/half lanes: word 0x20 preset to 0x11223344; byte write 0xAA to 0x21, then half write 0xBBCC to 0x22 -> read 0x20 = 0xBBCCAA44.
4. Errors: access to BASE_ADDR+4*MEM_DEPTH, a misaligned half at 0x1, and HSIZE=DWORD on a 32-bit bus -> each gives HREADYOUT 0/1 with HRESP 1/1 over 2 cycles and no memory change (verified by readback).
5. Back-to-back write 0x55 to 0x30 immediately followed by a read of 0x30 -> 0x55. BUSY beats inside a burst -> zero-wait OKAY with no memory access.
6. HRESETn low for one cycle during a WAIT-state write -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0; that write is not committed (readback shows the old value).
